// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 slice.
//   - CP0 register numbers used by mtc0/mfc0 (SR, Cause, EPC, PRId)
//   - bit positions of IM/IP, EXL and IE inside SR/Cause
//   - default PRId value
//   - a helper that packs the SR fields into their architectural word
// -----------------------------------------------------------------------------
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Field positions. IM (in SR) and IP (in Cause) share the same bit range
  // so they can be AND-ed directly to find pending, enabled interrupts.
  localparam int unsigned IRQ_W   = 6;
  localparam int unsigned IM_LSB  = 10;
  localparam int unsigned IM_MSB  = IM_LSB + IRQ_W - 1;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned IP_MSB  = IP_LSB + IRQ_W - 1;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;

  localparam logic [31:0] PRID_DEFAULT = 32'h0000_2022;

  typedef logic [IRQ_W-1:0] irq_t;

  // Architectural SR image; every bit outside IM/EXL/IE reads as zero.
  function automatic logic [31:0] sr_pack(input irq_t im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w                = '0;
    w[IM_MSB:IM_LSB] = im;
    w[EXL_BIT]       = exl;
    w[IE_BIT]        = ie;
    return w;
  endfunction

  // Architectural Cause image; only IP is implemented.
  function automatic logic [31:0] cause_pack(input irq_t ip);
    logic [31:0] w;
    w                = '0;
    w[IP_MSB:IP_LSB] = ip;
    return w;
  endfunction

endpackage : cp0_pkg

// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if
// mtc0/mfc0 access bus between the CPU datapath (master) and CP0 (slave).
//   we   : mtc0 write strobe
//   addr : CP0 register number for reads and writes
//   din  : mtc0 write data
//   dout : mfc0 read data (combinational from addr)
// -----------------------------------------------------------------------------
interface cp0_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output we, output addr, output din, input dout);
  modport slave  (input we, input addr, input din, output dout);
endinterface : cp0_if

// File: rtl/cp0.sv
// -----------------------------------------------------------------------------
// cp0
// Coprocessor 0: status, cause, exception PC and processor id registers,
// plus interrupt request generation.
// Ports:
//   clk      : system clock, all state changes on rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : mtc0/mfc0 access bus (we, addr, din, dout), slave side
//   pc       : address of the victim instruction
//   hwint    : device interrupt lines, hwint[0] is the timer
//   exl_set  : exception entry strobe
//   exl_clr  : eret strobe
//   intreq   : interrupt request to the controller
//   epc      : current EPC, eret target
// -----------------------------------------------------------------------------
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  cp0_if.slave        bus,
  input  logic [31:0] pc,
  input  logic [5:0]  hwint,
  input  logic        exl_set,
  input  logic        exl_clr,
  output logic        intreq,
  output logic [31:0] epc
);

  // SR fields
  irq_t        im_q,  im_d;
  logic        exl_q, exl_d;
  logic        ie_q,  ie_d;
  // Cause.IP
  irq_t        ip_q;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic [31:0] rdata;

  logic        sr_wr;
  logic        epc_wr;

  // The low two pc bits are discarded since EPC is always word aligned.
  logic        unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc[1:0];

  assign sr_wr  = bus.we && (bus.addr == REG_SR);
  assign epc_wr = bus.we && (bus.addr == REG_EPC);

  // ---------------------------------------------------------------------------
  // Interrupt pending sampler: free-running one-cycle capture of hwint.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q <= '0;
    end else begin
      ip_q <= hwint;
    end
  end

  // ---------------------------------------------------------------------------
  // SR / EPC next-state. Later assignments take priority, so exception entry
  // is applied last: it overrides both a software EPC write and an eret in the
  // same cycle, and forces EXL on top of a simultaneous SR write.
  // ---------------------------------------------------------------------------
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    epc_d = epc_q;

    if (sr_wr) begin
      im_d  = bus.din[IM_MSB:IM_LSB];
      exl_d = bus.din[EXL_BIT];
      ie_d  = bus.din[IE_BIT];
    end

    if (epc_wr) begin
      epc_d = {bus.din[31:2], 2'b00};
    end

    if (exl_clr) begin
      exl_d = 1'b0;
    end

    if (exl_set) begin
      exl_d = 1'b1;
      epc_d = {pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // mfc0 read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (bus.addr)
      REG_SR:    rdata = sr_pack(im_q, exl_q, ie_q);
      REG_CAUSE: rdata = cause_pack(ip_q);
      REG_EPC:   rdata = epc_q;
      REG_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

  assign bus.dout = rdata;

  // Registered state only, so no combinational path from hwint to intreq.
  assign intreq = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign epc    = epc_q;

endmodule : cp0

// File: tb/tb_cp0.sv
// -----------------------------------------------------------------------------
// tb_cp0
// Directed, table-driven bench for cp0 with hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_cp0;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [5:0]  hwint;
  logic        exl_set;
  logic        exl_clr;
  logic        intreq;
  logic [31:0] epc;

  cp0_if bus ();

  cp0 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pc      (pc),
    .hwint   (hwint),
    .exl_set (exl_set),
    .exl_clr (exl_clr),
    .intreq  (intreq),
    .epc     (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic [31:0] pc;
    logic [5:0]  hwint;
    logic        set;
    logic        clr;
    logic [4:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_int;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int unsigned NVEC = 16;
  vec_t vt[NVEC];

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a,
                        input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.dout, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //             we    waddr  din           pc            hw     set   clr   raddr  dout          int   epc
    vt[0]  = '{1'b0, 5'd0,  32'h0,        32'h0,        6'h00, 1'b0, 1'b0, 5'd15, 32'h0000_2022, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 5'd12, 32'h0000_0401, 32'h0,       6'h00, 1'b0, 1'b0, 5'd12, 32'h0000_0401, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        32'h0,        6'h01, 1'b0, 1'b0, 5'd13, 32'h0000_0400, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        32'h0000_3008, 6'h01, 1'b1, 1'b0, 5'd12, 32'h0000_0403, 1'b0, 32'h0000_3008};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        32'h0,        6'h01, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 1'b1, 32'h0000_3008};
    vt[5]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,       6'h01, 1'b0, 1'b0, 5'd13, 32'h0000_0400, 1'b1, 32'h0000_3008};
    vt[6]  = '{1'b1, 5'd15, 32'h0,        32'h0,        6'h01, 1'b0, 1'b0, 5'd15, 32'h0000_2022, 1'b1, 32'h0000_3008};
    vt[7]  = '{1'b1, 5'd14, 32'h0000_3007, 32'h0,       6'h01, 1'b0, 1'b0, 5'd14, 32'h0000_3004, 1'b1, 32'h0000_3004};
    vt[8]  = '{1'b1, 5'd12, 32'h0000_0001, 32'h0,       6'h3F, 1'b0, 1'b0, 5'd13, 32'h0000_FC00, 1'b0, 32'h0000_3004};
    vt[9]  = '{1'b1, 5'd14, 32'h0000_1234, 32'h0000_3010, 6'h3F, 1'b1, 1'b1, 5'd12, 32'h0000_0003, 1'b0, 32'h0000_3010};
    vt[10] = '{1'b1, 5'd12, 32'h0000_FC01, 32'h0000_3021, 6'h3F, 1'b1, 1'b0, 5'd12, 32'h0000_FC03, 1'b0, 32'h0000_3020};
    vt[11] = '{1'b0, 5'd0,  32'h0,        32'h0,        6'h3F, 1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b1, 32'h0000_3020};
    vt[12] = '{1'b1, 5'd12, 32'hFFFF_FFFE, 32'h0,       6'h3F, 1'b0, 1'b0, 5'd12, 32'h0000_FC02, 1'b0, 32'h0000_3020};
    vt[13] = '{1'b1, 5'd5,  32'hFFFF_FFFF, 32'h0,       6'h3F, 1'b0, 1'b0, 5'd5,  32'h0,         1'b0, 32'h0000_3020};
    vt[14] = '{1'b1, 5'd12, 32'h0000_0801, 32'h0,       6'h02, 1'b0, 1'b0, 5'd13, 32'h0000_0800, 1'b1, 32'h0000_3020};
    vt[15] = '{1'b0, 5'd0,  32'h0,        32'h0,        6'h00, 1'b0, 1'b0, 5'd13, 32'h0,         1'b0, 32'h0000_3020};

    // Reset with all interrupt lines high
    rst_n    = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 5'd0;
    bus.din  = '0;
    pc       = '0;
    hwint    = 6'h3F;
    exl_set  = 1'b0;
    exl_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst intreq", {31'b0, intreq}, 32'h0);
    chk("rst epc", epc, 32'h0);
    rd_chk("rst sr", 5'd12, 32'h0);
    rd_chk("rst cause", 5'd13, 32'h0);
    rd_chk("rst epcreg", 5'd14, 32'h0);

    @(negedge clk);
    hwint = 6'h00;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.we   = vt[i].we;
      bus.addr = vt[i].waddr;
      bus.din  = vt[i].din;
      pc       = vt[i].pc;
      hwint    = vt[i].hwint;
      exl_set  = vt[i].set;
      exl_clr  = vt[i].clr;
      @(posedge clk);
      #1;
      bus.we  = 1'b0;
      exl_set = 1'b0;
      exl_clr = 1'b0;
      bus.addr = vt[i].raddr;
      #1;
      chk($sformatf("v%0d dout", i), bus.dout, vt[i].exp_dout);
      chk($sformatf("v%0d intreq", i), {31'b0, intreq}, {31'b0, vt[i].exp_int});
      chk($sformatf("v%0d epc", i), epc, vt[i].exp_epc);
    end

    // Enter an exception, then assert reset between clock edges
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = 5'd12;
    bus.din  = 32'h0000_FC01;
    hwint    = 6'h3F;
    @(negedge clk);
    bus.we  = 1'b0;
    exl_set = 1'b1;
    pc      = 32'h0000_4000;
    @(posedge clk);
    #1;
    exl_set = 1'b0;
    rd_chk("exc sr", 5'd12, 32'h0000_FC03);
    chk("exc epc", epc, 32'h0000_4000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async intreq", {31'b0, intreq}, 32'h0);
    chk("async epc", epc, 32'h0);
    rd_chk("async sr", 5'd12, 32'h0);
    rd_chk("async cause", 5'd13, 32'h0);

    // First hwint sample only at the first edge after reset release
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post-rst cause pre-edge", 5'd13, 32'h0);
    @(posedge clk);
    #1;
    rd_chk("post-rst cause first edge", 5'd13, 32'h0000_FC00);
    chk("post-rst intreq", {31'b0, intreq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cp0

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- PRID  32'h0000_2022  constant value returned when reading register 15.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- we  in  1  mtc0 write strobe from the CPU.
- addr  in  5  CP0 register number for reads and writes.
- din  in  32  mtc0 write data.
- dout  out  32  mfc0 read data.
- pc  in  32  address of the victim instruction.
- hwint  in  6  device interrupt lines; hwint[0] is the timer intreq.
- exl_set  in  1  exception entry strobe from the controller.
- exl_clr  in  1  eret strobe from the controller.
- intreq  out  1  interrupt request to the controller.
- epc  out  32  current EPC, used as the eret target.

Function
REQ-003 Register map SHALL be: 12 SR {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; 13 Cause {16'b0, IP[15:10], 10'b0}; 14 EPC; 15 PRId.
REQ-004 Reads SHALL be combinational from addr: unimplemented bits read 0, unmapped addr reads 32'h0.
REQ-005 A write with we=1 to addr 12 SHALL load IM, EXL and IE from din at the clock edge; all other SR bits stay 0.
REQ-006 A write with we=1 to addr 14 SHALL load EPC with {din[31:2],2'b00}.
REQ-007 Writes to addr 13, addr 15 and unmapped addr SHALL be ignored.
REQ-008 Cause.IP SHALL sample hwint at every clock edge: one-cycle latency, not software-writable.
REQ-009 intreq SHALL equal |(IP & IM) & IE & ~EXL; it is combinational from registered state only.
REQ-010 exl_set SHALL, at the clock edge, set EXL=1 and load EPC with {pc[31:2],2'b00}.
REQ-011 exl_clr SHALL, at the clock edge, clear EXL to 0.
REQ-012 When exl_set and exl_clr are both high, exl_set SHALL win: EXL=1 and EPC is captured.
REQ-013 When exl_set and an SR write occur together, SR SHALL take IM and IE from din and force EXL=1.
REQ-014 When exl_set and an EPC write occur together, EPC SHALL take the pc value.
REQ-015 epc SHALL always equal the EPC register.
REQ-016 While EXL=1, intreq SHALL stay 0 regardless of IP, IM and IE.

Reset
REQ-017 When rst_n=0, SR, Cause.IP and EPC SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-018 Consequently intreq=0, epc=32'h0, and dout=0 for addr 12, 13 and 14 during reset.
REQ-019 Asserting rst_n mid-exception SHALL drop EXL and any pending IP bits.
REQ-020 The first sampling of hwint SHALL occur at the first clock edge after rst_n deasserts.

Structure
REQ-021 A shared package SHALL hold the register numbers (12/13/14/15), the bit positions of IM, IP, EXL and IE, and the PRID default.
REQ-022 The block SHALL be a single module with no sub-modules; the IP sampler and the SR/EPC registers are separate always blocks.

Verification
REQ-023 Reset check: rst_n=0 with hwint=6'h3F -> intreq=0 and reads of addr 12, 13, 14 return 0.
REQ-024 Timer interrupt:
- stimulus: write SR=32'h0000_0401 (IM[10]=1, IE=1), then raise hwint[0] at cycle N;
- response: intreq=1 in cycle N+1, and Cause reads 32'h0000_0400.
REQ-025 Exception entry:
- stimulus: with intreq=1, pulse exl_set with pc=32'h0000_3008;
- response: next cycle epc=32'h0000_3008, SR reads 32'h0000_0403, intreq=0.
- follow-up: pulse exl_clr -> intreq=1 again if hwint[0] is still high.
REQ-026 Simultaneous events:
- stimulus: exl_set + exl_clr + mtc0 EPC=32'h0000_1234 in the same cycle with pc=32'h0000_3010;
- response: EXL=1, epc=32'h0000_3010.
REQ-027 Masking: IE=1, IM=0, hwint=6'h3F -> intreq=0; writes to addr 13 (any din) and 15 leave Cause and PRId unchanged.
REQ-028 Alignment: mtc0 EPC with din=32'h0000_3007 -> epc=32'h0000_3004.
